am2922_scan: RTL and testbench
==============================

Name: am2922_scan

Overview:
- Sequencer that drives one Am2922 8-input multiplexer to scan its eight condition inputs serially and assemble an 8-bit status snapshot.
- Sits between microsequencer control logic and the Am2922. It owns the mux select, polarity, mux-enable, register-enable, output-enable and clear pins, and samples the mux Y output.
- Supports a per-channel enable mask, per-channel polarity, a programmable settle delay, abort, and continuous rescan.

Parameters:
- SETTLE, 0, number of extra wait cycles between latching the select and sampling Y (0..15).

Ports:
- clk  input  1  system clock, rising-edge active.
- clr_  input  1  asynchronous active-low reset.
- start  input  1  begin scan; sampled in IDLE only.
- abort  input  1  synchronous; ends scan and returns to IDLE.
- cont  input  1  continuous mode; rescans after each DONE while high.
- chmask  input  8  channel enable; bit n=1 scans channel n. Latched at start.
- polmask  input  8  per-channel polarity; drives the mux pol pin. Latched at start.
- mux_a, mux_b, mux_c  output  1 each  select to the Am2922 (c is MSB).
- mux_pol  output  1  polarity to the Am2922.
- mux_me_  output  1  mux enable, active-low.
- mux_re_  output  1  select register enable, active-low.
- mux_oe_  output  1  output enable, active-low.
- mux_clr_  output  1  Am2922 clear, active-low.
- mux_y  input  1  Am2922 Y output.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when snap is updated.
- snap  output  8  last completed snapshot; bit n = sampled Y of channel n.

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (clr_=0, asynchronous):
  - State IDLE, busy=0, done=0, snap=8'h00.
  - mux_a/b/c=0, mux_pol=0, mux_me_=1, mux_re_=1, mux_oe_=1, mux_clr_=0.
  - mux_clr_ releases to 1 on the first clock edge after clr_ deasserts.
- States: IDLE, LOAD, WAIT, SAMPLE, DONE.
- IDLE:
  - mux_oe_=1 and mux_me_=1.
  - On start=1 at an edge: latch chmask and polmask, clear shadow register, go to LOAD with ch = lowest enabled channel.
  - If latched chmask==0, go directly to DONE.
- LOAD (1 cycle):
  - Drive {c,b,a}=ch, pol=polmask[ch], me_=0, re_=0, oe_=0. The Am2922 latches on the closing edge.
  - Next state is WAIT if SETTLE>0, else SAMPLE.
- WAIT (SETTLE cycles): re_=1, other pins held.
- SAMPLE (1 cycle):
  - re_=1. On the closing edge, shadow[ch] <= mux_y.
  - Next state is LOAD for the next higher enabled channel, or DONE if none remain.
- DONE (1 cycle):
  - snap <= shadow at the entering edge; done=1 during this cycle.
  - Next state is LOAD (rescan with the same latched masks) if cont=1, else IDLE.
- Latency: with k enabled channels, done is high in cycle k*(2+SETTLE)+1 after the start edge. With SETTLE=0 and all channels enabled, that is cycle 17.
- Disabled channels are never selected; their snap bits are 0.
- start while busy: ignored. chmask/polmask changes mid-scan: ignored until the next IDLE start.
- abort=1 (not IDLE):
  - Next state IDLE, no done pulse, snap unchanged.
  - Outputs return to IDLE values at that edge.
- abort and start in the same IDLE cycle: abort wins, and the block stays IDLE.
- cont dropped during a scan: the current scan completes, then the block returns to IDLE.
- Reset mid-scan: immediate return to reset values, and the partial shadow is discarded.

Test Plan:
- Reset, then release clr_ -> all outputs at reset values. mux_clr_ rises one edge later, busy=0, snap=00.
- Am2922 d=8'hA5, chmask=FF, polmask=00, pulse start -> select visits 0..7 in order. done in cycle 17, snap=A5, busy drops the cycle after done.
- Same with polmask=FF -> snap=5A. Then polmask=0F -> snap=AA.
- chmask=8'h81, d=8'hFF -> only selects 0 and 7 are driven. done in cycle 5, snap=81.
- SETTLE=2, chmask=01, d=01 -> done in cycle 5, snap=01.
- Abort mid-scan: abort in cycle 6 -> IDLE next cycle, no done, snap keeps its previous value. Separately, clr_ pulsed mid-scan -> reset values, snap=00.
- cont=1, d changed between scans -> back-to-back done pulses 17 cycles apart, each snap matching the current d. cont=0 -> return to IDLE after the current DONE.

Source files
------------

// File: rtl/am2922_scan.sv
// Scan sequencer for one Am2922 8-input mux: walks the enabled channels in
// ascending order, samples Y for each and publishes an 8-bit snapshot.
module am2922_scan #(
    parameter int SETTLE = 0
) (
    input  logic       clk,
    input  logic       clr_,
    input  logic       start,
    input  logic       abort,
    input  logic       cont,
    input  logic [7:0] chmask,
    input  logic [7:0] polmask,
    output logic       mux_a,
    output logic       mux_b,
    output logic       mux_c,
    output logic       mux_pol,
    output logic       mux_me_,
    output logic       mux_re_,
    output logic       mux_oe_,
    output logic       mux_clr_,
    input  logic       mux_y,
    output logic       busy,
    output logic       done,
    output logic [7:0] snap
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ch_q, ch_d;
    logic [7:0] cm_q, cm_d;
    logic [7:0] pm_q, pm_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] snap_q, snap_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [2:0] sel_q, sel_d;
    logic       pol_q, pol_d;
    logic       me_q, me_d;
    logic       re_q, re_d;
    logic       oe_q, oe_d;
    logic       mclr_q, mclr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] above;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Enabled channels strictly above the current one.
    assign above = cm_q & (8'hFE << ch_q);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cm_d     = cm_q;
        pm_d     = pm_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        wcnt_d   = wcnt_q;
        sel_d    = sel_q;
        pol_d    = pol_q;
        me_d     = me_q;
        re_d     = re_q;
        oe_d     = oe_q;
        mclr_d   = 1'b1;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    cm_d     = chmask;
                    pm_d     = polmask;
                    shadow_d = 8'h00;
                    if (chmask == 8'h00) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                        ch_d    = lowest(chmask);
                    end
                end
            end
            LOAD: begin
                wcnt_d  = 4'd0;
                state_d = (SETTLE > 0) ? WAIT : SAMPLE;
            end
            WAIT: begin
                wcnt_d = wcnt_q + 4'd1;
                if (wcnt_q == 4'(SETTLE - 1)) state_d = SAMPLE;
            end
            SAMPLE: begin
                shadow_d[ch_q] = mux_y;
                if (above != 8'h00) begin
                    state_d = LOAD;
                    ch_d    = lowest(above);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cont) begin
                    shadow_d = 8'h00;
                    if (cm_q == 8'h00) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                        ch_d    = lowest(cm_q);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) state_d = IDLE;

        // Pins are decoded from the next state so every output is a flop.
        case (state_d)
            IDLE: begin
                sel_d = 3'd0;
                pol_d = 1'b0;
                me_d  = 1'b1;
                re_d  = 1'b1;
                oe_d  = 1'b1;
            end
            LOAD: begin
                sel_d = ch_d;
                pol_d = pm_d[ch_d];
                me_d  = 1'b0;
                re_d  = 1'b0;
                oe_d  = 1'b0;
            end
            default: re_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        if (state_d == DONE) snap_d = shadow_d;
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state_q  <= IDLE;
            ch_q     <= 3'd0;
            cm_q     <= 8'h00;
            pm_q     <= 8'h00;
            shadow_q <= 8'h00;
            snap_q   <= 8'h00;
            wcnt_q   <= 4'd0;
            sel_q    <= 3'd0;
            pol_q    <= 1'b0;
            me_q     <= 1'b1;
            re_q     <= 1'b1;
            oe_q     <= 1'b1;
            mclr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cm_q     <= cm_d;
            pm_q     <= pm_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            wcnt_q   <= wcnt_d;
            sel_q    <= sel_d;
            pol_q    <= pol_d;
            me_q     <= me_d;
            re_q     <= re_d;
            oe_q     <= oe_d;
            mclr_q   <= mclr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mux_a    = sel_q[0];
    assign mux_b    = sel_q[1];
    assign mux_c    = sel_q[2];
    assign mux_pol  = pol_q;
    assign mux_me_  = me_q;
    assign mux_re_  = re_q;
    assign mux_oe_  = oe_q;
    assign mux_clr_ = mclr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign snap     = snap_q;

endmodule

// File: tb/tb_am2922_scan.sv
// Bench for am2922_scan: two instances (SETTLE=0 and SETTLE=2), each wired to
// a behavioural Am2922; a monitor checks selects, snapshots and done timing.
module tb_am2922_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_, abort, cont;
    logic [7:0] chmask, polmask, d;
    logic       start_w   [2];
    logic       mux_a_w   [2];
    logic       mux_b_w   [2];
    logic       mux_c_w   [2];
    logic       mux_pol_w [2];
    logic       mux_me_w  [2];
    logic       mux_re_w  [2];
    logic       mux_oe_w  [2];
    logic       mux_clr_w [2];
    logic       y_w       [2];
    logic       busy_w    [2];
    logic       done_w    [2];
    logic [7:0] snap_w    [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [2:0] lsel;
        logic       lpol;
        always @(posedge clk) begin
            if (!mux_clr_w[g]) begin
                lsel <= 3'd0;
                lpol <= 1'b0;
            end else if (!mux_re_w[g]) begin
                lsel <= {mux_c_w[g], mux_b_w[g], mux_a_w[g]};
                lpol <= mux_pol_w[g];
            end
        end
        assign y_w[g] = (!mux_oe_w[g] && !mux_me_w[g]) ? (d[lsel] ^ lpol) : 1'b0;

        am2922_scan #(.SETTLE(2 * g)) u_dut (
            .clk(clk), .clr_(clr_), .start(start_w[g]), .abort(abort), .cont(cont),
            .chmask(chmask), .polmask(polmask),
            .mux_a(mux_a_w[g]), .mux_b(mux_b_w[g]), .mux_c(mux_c_w[g]),
            .mux_pol(mux_pol_w[g]), .mux_me_(mux_me_w[g]), .mux_re_(mux_re_w[g]),
            .mux_oe_(mux_oe_w[g]), .mux_clr_(mux_clr_w[g]), .mux_y(y_w[g]),
            .busy(busy_w[g]), .done(done_w[g]), .snap(snap_w[g])
        );
    end

    logic [3:0] exp_sel_q  [2][$];
    logic [7:0] exp_snap_q [2][$];
    int         exp_cyc_q  [2][$];
    logic [7:0] model_snap [2];
    logic       prev_done  [2];
    logic       prev_cont;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d: got %0h want %0h (cycle %0d)", name, g, act, exp, cyc);
        end
    endtask

    // Reference: every enabled channel is visited in ascending order, each
    // snapshot bit is d^pol for enabled channels, done arrives k*(2+S)+1 cycles on.
    task automatic push_scan(input int g, input logic [7:0] cm, input logic [7:0] pm,
                             input logic [7:0] dv, input int e);
        int k;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (cm[i]) begin
                exp_sel_q[g].push_back({pm[i], 3'(i)});
                k++;
            end
        end
        exp_snap_q[g].push_back(cm & (dv ^ pm));
        exp_cyc_q[g].push_back(e + k * (2 + 2 * g));
    endtask

    task automatic flush(input int g);
        exp_sel_q[g].delete();
        exp_snap_q[g].delete();
        exp_cyc_q[g].delete();
    endtask

    task automatic monitor_loop();
        logic [3:0] es;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (prev_done[g] && !prev_cont) chk("busy_after_done", g, 32'(busy_w[g]), 0);
                prev_done[g] = done_w[g];
                if (done_w[g]) begin
                    if (exp_snap_q[g].size() == 0) begin
                        chk("unexpected_done", g, 32'(done_w[g]), 0);
                    end else begin
                        model_snap[g] = exp_snap_q[g].pop_front();
                        chk("snap", g, 32'(snap_w[g]), 32'(model_snap[g]));
                        chk("done_cycle", g, cyc, exp_cyc_q[g].pop_front());
                    end
                end
                if (!mux_re_w[g]) begin
                    if (exp_sel_q[g].size() == 0) begin
                        chk("unexpected_load", g, 32'(mux_re_w[g]), 1);
                    end else begin
                        es = exp_sel_q[g].pop_front();
                        chk("select", g, 32'({mux_pol_w[g], mux_c_w[g], mux_b_w[g], mux_a_w[g]}),
                            32'(es));
                    end
                end
            end
            prev_cont = cont;
        end
    endtask

    task automatic start_scan(input int g, input logic [7:0] cm, input logic [7:0] pm,
                              input logic [7:0] dv);
        @(posedge clk); #1;
        d = dv; chmask = cm; polmask = pm; start_w[g] = 1'b1;
        @(posedge clk); #1;
        start_w[g] = 1'b0;
        push_scan(g, cm, pm, dv, cyc);
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_w[g] && n < 200);
        chk("scan_ends", g, 32'(busy_w[g]), 0);
        chk("exp_drained", g, exp_snap_q[g].size() + exp_sel_q[g].size(), 0);
    endtask

    task automatic wait_done(input int g);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_w[g] && n < 200);
        chk("done_seen", g, 32'(done_w[g]), 1);
    endtask

    task automatic run_scan(input int g, input logic [7:0] cm, input logic [7:0] pm,
                            input logic [7:0] dv);
        start_scan(g, cm, pm, dv);
        wait_idle(g);
    endtask

    task automatic check_reset_pins(input int g);
        chk("reset_pins", g, 32'({mux_c_w[g], mux_b_w[g], mux_a_w[g], mux_pol_w[g],
                                  mux_me_w[g], mux_re_w[g], mux_oe_w[g], mux_clr_w[g]}),
            32'h0E);
        chk("reset_busy_done", g, 32'({busy_w[g], done_w[g]}), 0);
        chk("reset_snap", g, 32'(snap_w[g]), 0);
    endtask

    initial begin
        logic [7:0] nd, cm, pm, dv;
        int g;
        clr_ = 1'b0; abort = 1'b0; cont = 1'b0;
        chmask = 8'h00; polmask = 8'h00; d = 8'h00;
        prev_cont = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_w[i] = 1'b0; model_snap[i] = 8'h00; prev_done[i] = 1'b0;
        end
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) check_reset_pins(i);
        @(posedge clk); #1 clr_ = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("clr_hold", i, 32'(mux_clr_w[i]), 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("clr_release", i, 32'(mux_clr_w[i]), 1);

        run_scan(0, 8'hFF, 8'h00, 8'hA5);
        run_scan(0, 8'hFF, 8'hFF, 8'hA5);
        run_scan(0, 8'hFF, 8'h0F, 8'hA5);
        run_scan(0, 8'h81, 8'h00, 8'hFF);
        run_scan(0, 8'h00, 8'hFF, 8'hFF);
        run_scan(1, 8'h01, 8'h00, 8'h01);
        run_scan(1, 8'hFF, 8'h3C, 8'h96);

        // A second start while busy must not reload the masks.
        start_scan(0, 8'hFF, 8'h00, 8'h5A);
        repeat (4) @(posedge clk);
        #1 chmask = 8'h0F; polmask = 8'hFF; start_w[0] = 1'b1;
        @(posedge clk); #1 start_w[0] = 1'b0;
        wait_idle(0);

        @(posedge clk); #1 abort = 1'b1; start_w[0] = 1'b1; chmask = 8'hFF;
        @(posedge clk); #1 abort = 1'b0; start_w[0] = 1'b0;
        @(negedge clk);
        chk("abort_beats_start", 0, 32'(busy_w[0]), 0);

        // Abort sampled at the end of cycle 6 of a full scan.
        start_scan(0, 8'hFF, 8'h00, 8'h33);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 0, 32'(busy_w[0]), 0);
        chk("abort_done", 0, 32'(done_w[0]), 0);
        chk("abort_snap", 0, 32'(snap_w[0]), 32'(model_snap[0]));
        chk("abort_pins", 0, 32'({mux_me_w[0], mux_re_w[0], mux_oe_w[0]}), 32'h7);
        flush(0);

        for (int i = 0; i < 20; i++) begin
            g  = int'($urandom_range(0, 1));
            cm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            pm = 8'($urandom);
            dv = 8'($urandom);
            run_scan(g, cm, pm, dv);
        end

        // Continuous mode with a fresh d for every rescan.
        cont = 1'b1;
        start_scan(0, 8'hFF, 8'h00, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            wait_done(0);
            @(posedge clk); #1;
            nd = 8'($urandom);
            d  = nd;
            push_scan(0, 8'hFF, 8'h00, nd, cyc);
            if (i == 2) cont = 1'b0;
        end
        wait_idle(0);

        start_scan(1, 8'hFF, 8'h00, 8'h77);
        repeat (7) @(posedge clk);
        #1 clr_ = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            check_reset_pins(i);
            flush(i);
            model_snap[i] = 8'h00;
        end
        @(posedge clk); #1 clr_ = 1'b1;
        run_scan(1, 8'hF0, 8'h0F, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
